// File: rtl/watch_wb_regs_if.sv
// Wishbone classic slave link between the management SoC wrapper and watch_wb_regs.
// Signal names follow the wrapper's wbs_* port, seen from the slave.
interface watch_wb_regs_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/watch_wb_regs.sv
// Wishbone register block for the watch core: prescaler, hh:mm:ss counter, alarm interrupt.
// Define WATCH_ALARM_EN to build the ALARM register, AEN/PEND bits and irq_o.
module watch_wb_regs #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] PRESCALE_RST = 32'd9_999_999
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  watch_wb_regs_if.slave wbs,
  output logic           tick_o,
  output logic [20:0]    time_o,
  output logic           irq_o
);

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffPresc  = 3'd1;
  localparam logic [2:0] OffTime   = 3'd2;
  localparam logic [2:0] OffAlarm  = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        tick_q, tick_d;
  logic        run_q, run_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  hh_q, hh_d, hh_inc, hh_wr;
  logic [5:0]  mm_q, mm_d, mm_inc, mm_wr;
  logic [5:0]  ss_q, ss_d, ss_inc, ss_wr;

  logic        in_win, req, wr, tick;
  logic [2:0]  off;
  logic [31:0] wmask, rd_word, merged;
  logic [20:0] time_cur, time_inc, alarm_cur;
  logic        aen, pend;
  logic        unused_adr;

`ifdef WATCH_ALARM_EN
  logic       aen_q, aen_d;
  logic       pend_q, pend_d;
  logic [4:0] al_hh_q, al_hh_d;
  logic [5:0] al_mm_q, al_mm_d;
  logic [5:0] al_ss_q, al_ss_d;

  assign aen       = aen_q;
  assign pend      = pend_q;
  assign alarm_cur = {al_hh_q, 2'b00, al_mm_q, 2'b00, al_ss_q};
  assign irq_o     = pend_q & aen_q;
`else
  assign aen       = 1'b0;
  assign pend      = 1'b0;
  assign alarm_cur = '0;
  assign irq_o     = 1'b0;
`endif

  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  assign in_win = (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign off    = wbs.wbs_adr_i[4:2];
  assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & in_win;
  // Writes commit on the edge that ends the ack cycle, so a reset during ack drops them.
  assign wr     = ack_q & wbs.wbs_cyc_i & wbs.wbs_stb_i & wbs.wbs_we_i & in_win;
  assign tick   = run_q & (cnt_q == presc_q);

  assign time_cur = {hh_q, 2'b00, mm_q, 2'b00, ss_q};
  assign time_inc = {hh_inc, 2'b00, mm_inc, 2'b00, ss_inc};

  assign wmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                  {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

  always_comb begin
    rd_word = '0;
    case (off)
      OffCtrl:   rd_word = {30'd0, aen, run_q};
      OffPresc:  rd_word = presc_q;
      OffTime:   rd_word = {11'd0, time_cur};
      OffAlarm:  rd_word = {11'd0, alarm_cur};
      OffStatus: rd_word = {30'd0, run_q, pend};
      default:   rd_word = '0;
    endcase
  end

  // Byte-lane merge against the current register value, then per-field range clamp.
  always_comb begin
    merged = (rd_word & ~wmask) | (wbs.wbs_dat_i & wmask);
    hh_wr  = (merged[20:16] > 5'd23) ? 5'd0 : merged[20:16];
    mm_wr  = (merged[13:8]  > 6'd59) ? 6'd0 : merged[13:8];
    ss_wr  = (merged[5:0]   > 6'd59) ? 6'd0 : merged[5:0];
  end

  always_comb begin
    ss_inc = ss_q + 6'd1;
    mm_inc = mm_q;
    hh_inc = hh_q;
    if (ss_q == 6'd59) begin
      ss_inc = 6'd0;
      mm_inc = mm_q + 6'd1;
      if (mm_q == 6'd59) begin
        mm_inc = 6'd0;
        hh_inc = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
      end
    end
  end

  always_comb begin
    ack_d   = req;
    dat_d   = req ? rd_word : 32'd0;
    tick_d  = tick;
    run_d   = run_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
`ifdef WATCH_ALARM_EN
    aen_d   = aen_q;
    pend_d  = pend_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    al_ss_d = al_ss_q;
`endif

    if (tick) begin
      cnt_d = 32'd0;
      hh_d  = hh_inc;
      mm_d  = mm_inc;
      ss_d  = ss_inc;
    end else if (run_q) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (wr) begin
      case (off)
        OffCtrl: begin
          run_d = merged[0];
`ifdef WATCH_ALARM_EN
          aen_d = merged[1];
`endif
        end
        OffPresc: presc_d = merged;
        OffTime: begin
          // A time write overrides any increment and restarts the second.
          hh_d  = hh_wr;
          mm_d  = mm_wr;
          ss_d  = ss_wr;
          cnt_d = 32'd0;
        end
`ifdef WATCH_ALARM_EN
        OffAlarm: begin
          al_hh_d = hh_wr;
          al_mm_d = mm_wr;
          al_ss_d = ss_wr;
        end
        OffStatus: begin
          if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) pend_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end

`ifdef WATCH_ALARM_EN
    // Set after the W1C so a simultaneous alarm wins.
    if (tick && !(wr && off == OffTime) && aen_q && (time_inc == alarm_cur)) pend_d = 1'b1;
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      presc_q <= PRESCALE_RST;
      cnt_q   <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
`ifdef WATCH_ALARM_EN
      aen_q   <= 1'b0;
      pend_q  <= 1'b0;
      al_hh_q <= '0;
      al_mm_q <= '0;
      al_ss_q <= '0;
`endif
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
`ifdef WATCH_ALARM_EN
      aen_q   <= aen_d;
      pend_q  <= pend_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      al_ss_q <= al_ss_d;
`endif
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign tick_o        = tick_q;
  assign time_o        = time_cur;

endmodule

// File: tb/tb_watch_wb_regs.sv
// Self-checking bench for watch_wb_regs: seconds-count reference model checked every cycle
// plus directed transactions with literal expectations.
module tb_watch_wb_regs;

`ifdef WATCH_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick;
  logic [20:0] tm;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  watch_wb_regs_if bus ();

  watch_wb_regs dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs     (bus),
    .tick_o  (tick),
    .time_o  (tm),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  // Reference state: time kept as seconds since midnight.
  int unsigned m_secs  = 0;
  int unsigned m_alarm = 0;
  logic [31:0] m_p     = 32'd9_999_999;
  logic [31:0] m_cnt   = 0;
  bit          m_run   = 0;
  bit          m_aen   = 0;
  bit          m_pend  = 0;
  bit          m_ack   = 0;
  bit          m_tick  = 0;
  logic [31:0] m_dat   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int unsigned t);
    logic [31:0] r;
    r        = '0;
    r[20:16] = 5'(t / 3600);
    r[13:8]  = 6'((t / 60) % 60);
    r[5:0]   = 6'(t % 60);
    return r;
  endfunction

  function automatic int unsigned clamp_secs(input logic [31:0] w);
    int unsigned h, m, s;
    h = w[20:16];
    m = w[13:8];
    s = w[5:0];
    if (h > 23) h = 0;
    if (m > 59) m = 0;
    if (s > 59) s = 0;
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return {30'd0, m_aen, m_run};
      1:       return m_p;
      2:       return pack(m_secs);
      3:       return AlarmEn ? pack(m_alarm) : 32'd0;
      4:       return {30'd0, m_run, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit          inwin, req, wr, tk, setp;
    int          off;
    logic [31:0] mask, old, mg;
    int unsigned n_secs, n_alarm;
    logic [31:0] n_p, n_cnt;
    bit          n_run, n_aen, n_pend;
    inwin = (bus.wbs_adr_i >= 32'h3000_0000) && (bus.wbs_adr_i < 32'h3000_0020);
    off   = inwin ? int'((bus.wbs_adr_i - 32'h3000_0000) / 4) : 7;
    req   = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack && inwin;
    wr    = m_ack && bus.wbs_cyc_i && bus.wbs_stb_i && bus.wbs_we_i && inwin;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = bus.wbs_sel_i[b] ? 8'hFF : 8'h00;
    old     = model_read(off);
    mg      = (old & ~mask) | (bus.wbs_dat_i & mask);
    tk      = m_run && (m_cnt == m_p);
    n_secs  = m_secs;  n_alarm = m_alarm; n_p = m_p; n_cnt = m_cnt;
    n_run   = m_run;   n_aen = m_aen;     n_pend = m_pend;
    setp    = 0;
    if (tk) begin
      n_cnt  = 0;
      n_secs = (m_secs + 1) % 86400;
      if (!(wr && off == 2) && AlarmEn && m_aen && n_secs == m_alarm) setp = 1;
    end else if (m_run) begin
      n_cnt = m_cnt + 1;
    end
    if (wr) begin
      case (off)
        0: begin n_run = mg[0]; if (AlarmEn) n_aen = mg[1]; end
        1: n_p = mg;
        2: begin n_secs = clamp_secs(mg); n_cnt = 0; end
        3: if (AlarmEn) n_alarm = clamp_secs(mg);
        4: if (AlarmEn && bus.wbs_sel_i[0] && bus.wbs_dat_i[0]) n_pend = 0;
        default: ;
      endcase
    end
    if (setp) n_pend = 1;
    m_tick = tk;
    m_ack  = req;
    m_dat  = req ? old : 32'd0;
    m_secs = n_secs; m_alarm = n_alarm; m_p = n_p; m_cnt = n_cnt;
    m_run  = n_run;  m_aen = n_aen;     m_pend = n_pend;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_secs = 0; m_alarm = 0; m_p = 32'd9_999_999; m_cnt = 0;
      m_run = 0; m_aen = 0; m_pend = 0; m_ack = 0; m_tick = 0; m_dat = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("ack", {31'd0, bus.wbs_ack_o}, {31'd0, m_ack});
    chk("dat", bus.wbs_dat_o, m_dat);
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
    chk("time", {11'd0, tm}, pack(m_secs));
    chk("irq", {31'd0, irq}, {31'd0, m_pend & m_aen});
  end

  // Called at a negedge; returns at the negedge after the commit edge (or after the budget).
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [3:0] sel, input int budget,
                      output logic [31:0] rd, output int lat);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = wd;
    lat = -1;
    rd  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        lat = i;
        rd  = bus.wbs_dat_o;
        break;
      end
    end
    if (lat > 0) @(negedge clk);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
  endtask

  task automatic do_wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    int          lat;
    xfer(1'b1, adr, d, sel, 8, r, lat);
    chk("wr_ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic do_rd(input logic [31:0] adr, output logic [31:0] r);
    int lat;
    xfer(1'b0, adr, 32'd0, 4'hF, 8, r, lat);
    chk("rd_ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    int          lat, n;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_time", {11'd0, tm}, 32'd0);
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Reset value of PRESCALE, and an out-of-window address
    xfer(1'b0, 32'h3000_0004, 32'd0, 4'hF, 8, r, lat);
    chk("presc_lat", 32'(lat), 32'd1);
    chk("presc_rst", r, 32'h0098_967F);
    xfer(1'b0, 32'h3000_0020, 32'd0, 4'hF, 16, r, lat);
    chk("oor_noack", 32'(lat), 32'hFFFF_FFFF);
    @(negedge clk);

    // P=3: tick every 4 cycles
    do_wr(32'h3000_0004, 32'd3, 4'hF);
    do_wr(32'h3000_0000, 32'd1, 4'hF);
    wait_tick(20, n); chk("t2_first_tick", 32'(n), 32'd4);
    wait_tick(20, n); chk("t2_period2", 32'(n), 32'd4);
    wait_tick(20, n); chk("t2_period3", 32'(n), 32'd4);
    chk("t2_time_o", {11'd0, tm}, 32'h0000_0003);
    do_wr(32'h3000_0000, 32'd0, 4'hF);
    do_rd(32'h3000_0008, r);
    chk("t2_time_rd", r, 32'h0000_0003);

    // Midnight wrap with P=0
    do_wr(32'h3000_0008, 32'h0017_3B3B, 4'hF);
    do_wr(32'h3000_0004, 32'd0, 4'hF);
    do_wr(32'h3000_0000, 32'd1, 4'hF);
    chk("t3_pre_time", {11'd0, tm}, 32'h0017_3B3B);
    @(negedge clk);
    chk("t3_wrap_time", {11'd0, tm}, 32'd0);
    chk("t3_wrap_tick", {31'd0, tick}, 32'd1);
    do_wr(32'h3000_0000, 32'd0, 4'hF);

    // Range clamp and byte-lane merge
    do_wr(32'h3000_0008, 32'h0018_3C3D, 4'hF);
    do_rd(32'h3000_0008, r);
    chk("t4_clamp", r, 32'd0);
    do_wr(32'h3000_0008, 32'h0001_0203, 4'hF);
    do_wr(32'h3000_0008, 32'h0000_0005, 4'b0001);
    do_rd(32'h3000_0008, r);
    chk("t4_bytewr", r, 32'h0001_0205);
    do_rd(32'h3000_001C, r);
    chk("t4_reserved", r, 32'd0);

`ifdef WATCH_ALARM_EN
    do_wr(32'h3000_000C, 32'h0000_0002, 4'hF);
    do_wr(32'h3000_0008, 32'd0, 4'hF);
    do_wr(32'h3000_0004, 32'd1, 4'hF);
    do_wr(32'h3000_0000, 32'd3, 4'hF);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (irq) begin n = i; break; end
    end
    chk("t5_irq_cycle", 32'(n), 32'd4);
    chk("t5_irq_time", {11'd0, tm}, 32'd2);
    chk("t5_irq_tick", {31'd0, tick}, 32'd1);
    do_wr(32'h3000_0010, 32'd1, 4'hF);
    chk("t5_irq_clear", {31'd0, irq}, 32'd0);
    do_rd(32'h3000_0000, r);
    chk("t5_ctrl", r, 32'd3);
    do_wr(32'h3000_0000, 32'd0, 4'hF);
`else
    do_wr(32'h3000_0000, 32'd3, 4'hF);
    do_rd(32'h3000_0000, r);
    chk("t5_ctrl_noaen", r, 32'd1);
    do_wr(32'h3000_000C, 32'h0000_0005, 4'hF);
    do_rd(32'h3000_000C, r);
    chk("t5_alarm_absent", r, 32'd0);
    chk("t5_irq_tied", {31'd0, irq}, 32'd0);
    do_wr(32'h3000_0000, 32'd0, 4'hF);
`endif

    // TIME write landing on a tick edge
    do_wr(32'h3000_0004, 32'd3, 4'hF);
    do_wr(32'h3000_0008, 32'd0, 4'hF);
    do_wr(32'h3000_0000, 32'd1, 4'hF);
    wait_tick(20, n);
    chk("t6_sync_tick", {31'd0, n > 0}, 32'd1);
    repeat (2) @(negedge clk);
    do_wr(32'h3000_0008, 32'h0005_0000, 4'hF);
    chk("t6_write_wins", {11'd0, tm}, 32'h0005_0000);
    wait_tick(20, n);
    chk("t6_restart", 32'(n), 32'd4);
    do_wr(32'h3000_0000, 32'd0, 4'hF);

    // Reset while ack is high: ack drops, the write never lands
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0008; bus.wbs_dat_i = 32'h0001_0101;
    @(negedge clk);
    chk("t7_ack_before", {31'd0, bus.wbs_ack_o}, 32'd1);
    #2 rst = 1;
    #1 chk("t7_ack_dropped", {31'd0, bus.wbs_ack_o}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t7_ack_in_rst", {31'd0, bus.wbs_ack_o}, 32'd0);
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    rst = 0;
    do_rd(32'h3000_0008, r);
    chk("t7_time_rst", r, 32'd0);
    do_rd(32'h3000_0004, r);
    chk("t7_presc_rst", r, 32'h0098_967F);
    do_rd(32'h3000_0000, r);
    chk("t7_ctrl_rst", r, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
